// File: rtl/rms_drv_pkg.sv
// Shared types for the RMS frame driver: FSM state encoding and error codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rms_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_CLEAR    = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_STREAM   = 3'd4,
    ST_WAIT_RES = 3'd5,
    ST_HOLD     = 3'd6
  } state_e;

  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_CORE = 2'd3;

endpackage

// File: rtl/rms_frame_driver_if.sv
// Bus bundle between host/test fabric, the frame driver and the RMS core.
// Latency: n/a (wiring only).
// Backpressure: s_valid/s_ready on samples, res_valid/res_ready on results.
//  slave modport  : driver view (host + core inputs in, core drive + result out)
//  master modport : environment view (opposite directions)
interface rms_frame_driver_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 12,
  parameter int LEN_W  = 5
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [LEN_W-1:0]  frame_len;
  logic              start;
  logic              busy;
  logic [DATA_W-1:0] core_data;
  logic              core_valid;
  logic              core_rdy;
  logic              core_clr;
  logic [RES_W-1:0]  core_res;
  logic              core_res_valid;
  logic              core_err_valid;
  logic [RES_W-1:0]  res_data;
  logic              res_valid;
  logic              res_ready;
  logic              err_valid;
  logic [1:0]        err_code;

  modport slave (
    input  s_data, s_valid, frame_len, start, core_rdy, core_res,
           core_res_valid, core_err_valid, res_ready,
    output s_ready, busy, core_data, core_valid, core_clr, res_data,
           res_valid, err_valid, err_code
  );

  modport master (
    output s_data, s_valid, frame_len, start, core_rdy, core_res,
           core_res_valid, core_err_valid, res_ready,
    input  s_ready, busy, core_data, core_valid, core_clr, res_data,
           res_valid, err_valid, err_code
  );
endinterface

// File: rtl/rms_drv_fifo.sv
// Sample FIFO: one push per cycle, pop of 0..DEPTH entries per cycle (bulk drop on abort).
// Latency: head shows the oldest entry combinationally; push visible in level next cycle.
// Backpressure: push_rdy is registered !full (0 during reset); caller pushes only when set.
//  ports: clk, rst (sync, active-high), push/push_data, pop_n, head, level, full, empty, push_rdy
module rms_drv_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [LVL_W-1:0]  pop_n,
  output logic [DATA_W-1:0] head,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic              push_rdy
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [LVL_W:0]    rd_sum;
  logic [LVL_W-1:0]  level_nxt;

  // Read pointer may jump by several entries; wrap modulo DEPTH explicitly.
  always_comb begin
    rd_sum    = (LVL_W+1)'(rd_ptr) + (LVL_W+1)'(pop_n);
    rd_nxt    = (rd_sum >= (LVL_W+1)'(DEPTH)) ? PTR_W'(rd_sum - (LVL_W+1)'(DEPTH))
                                              : PTR_W'(rd_sum);
    wr_nxt    = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    level_nxt = level + LVL_W'(push) - pop_n;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      push_rdy <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_nxt;
      rd_ptr   <= rd_nxt;
      level    <= level_nxt;
      push_rdy <= (level_nxt != LVL_W'(DEPTH));
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
endmodule

// File: rtl/rms_frame_driver.sv
// Buffers host samples and replays one frame as a gap-free burst to the RMS core, returns result.
// Latency: start at T (level>=len, core_rdy=1) -> core_clr at T+2, first beat at T+4.
// Backpressure: s_ready = registered !full; result held on res_valid until res_ready.
//  ports: clk, rst (sync, active-high), bus (rms_frame_driver_if.slave: host, core, result, error)
//  optional: RMS_DRV_TIMEOUT_EN enables the WAIT_RDY/WAIT_RES watchdog (error code 2).
module rms_frame_driver
  import rms_drv_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 12,
  parameter int DEPTH   = 16,
  parameter int LEN_W   = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  rms_frame_driver_if.slave  bus
);
  state_e            state_q;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic [DATA_W-1:0] core_data_q;
  logic              core_valid_q, core_clr_q;
  logic [RES_W-1:0]  res_data_q;
  logic              res_valid_q, err_valid_q;
  logic [1:0]        err_code_q;

  logic              fifo_push, fifo_rdy, fifo_full, fifo_empty;
  logic [LEN_W-1:0]  fifo_level, pop_n;
  logic [DATA_W-1:0] fifo_head;
  logic              busy_w, core_err, beat_load, tmo_hit;
  logic              unused_fifo_flags;

  assign fifo_push         = bus.s_valid && fifo_rdy;
  assign unused_fifo_flags = fifo_full ^ fifo_empty;

  rms_drv_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LVL_W(LEN_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bus.s_data),
    .pop_n     (pop_n),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_rdy  (fifo_rdy)
  );

`ifdef RMS_DRV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             in_wait;

  // Both wait states are only entered from non-wait states, so a plain
  // clear-outside-wait restarts the count on every entry.
  assign in_wait = (state_q == ST_WAIT_RDY) || (state_q == ST_WAIT_RES);
  assign tmo_hit = in_wait && (tmo_q == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_wait) tmo_q <= '0;
    else                 tmo_q <= tmo_q + TMO_W'(1);
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT != 0);
  assign tmo_hit    = 1'b0;
`endif

  assign busy_w    = (state_q != ST_IDLE);
  assign core_err  = bus.core_err_valid && busy_w;
  assign beat_load = ((state_q == ST_WAIT_RDY) && bus.core_rdy) ||
                     ((state_q == ST_STREAM) && (cnt_q != '0));

  // On a core error, drop whatever of the current frame is still in the FIFO.
  // In STREAM cnt_q already excludes the beat on the wire.
  always_comb begin
    pop_n = '0;
    if (core_err) begin
      case (state_q)
        ST_ARM:                pop_n = (fifo_level < len_q) ? fifo_level : len_q;
        ST_CLEAR, ST_WAIT_RDY: pop_n = len_q;
        ST_STREAM:             pop_n = cnt_q;
        default:               pop_n = '0;
      endcase
    end else if (beat_load && !tmo_hit) begin
      pop_n = LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      core_data_q  <= '0;
      core_valid_q <= 1'b0;
      core_clr_q   <= 1'b0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
    end else begin
      err_valid_q  <= 1'b0;
      core_clr_q   <= 1'b0;
      core_valid_q <= 1'b0;
      if (core_err) begin
        err_valid_q <= 1'b1;
        err_code_q  <= ERR_CORE;
        res_valid_q <= 1'b0;
        state_q     <= ST_IDLE;
      end else if (tmo_hit) begin
        err_valid_q <= 1'b1;
        err_code_q  <= ERR_TMO;
        state_q     <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (bus.start) begin
            len_q <= bus.frame_len;
            if ((bus.frame_len == '0) || (bus.frame_len > LEN_W'(DEPTH))) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_LEN;
            end else begin
              state_q <= ST_ARM;
            end
          end
          ST_ARM: if (fifo_level >= len_q) begin
            core_clr_q <= 1'b1;
            state_q    <= ST_CLEAR;
          end
          ST_CLEAR: state_q <= ST_WAIT_RDY;
          // The beat register is loaded on the edge that enters STREAM, so
          // core_valid is high for every STREAM cycle and drops right after.
          ST_WAIT_RDY: if (bus.core_rdy) begin
            core_valid_q <= 1'b1;
            core_data_q  <= fifo_head;
            cnt_q        <= len_q - LEN_W'(1);
            state_q      <= ST_STREAM;
          end
          ST_STREAM: begin
            if (cnt_q != '0) begin
              core_valid_q <= 1'b1;
              core_data_q  <= fifo_head;
              cnt_q        <= cnt_q - LEN_W'(1);
            end else begin
              state_q <= ST_WAIT_RES;
            end
          end
          ST_WAIT_RES: if (bus.core_res_valid) begin
            res_data_q  <= bus.core_res;
            res_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
          ST_HOLD: if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.s_ready    = fifo_rdy;
  assign bus.busy       = busy_w;
  assign bus.core_data  = core_data_q;
  assign bus.core_valid = core_valid_q;
  assign bus.core_clr   = core_clr_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_code   = err_code_q;
endmodule
